// File: rtl/boot_loader.sv
// Byte-stream boot loader driving the CPU bootloader write port.
// Build option BOOT_CHECKSUM_EN appends a 32-bit frame checksum check.
module boot_loader #(
    parameter int unsigned ADDR_STRIDE    = 4,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        debug,
    output logic [31:0] data_cpu,
    output logic [31:0] waddr_cpu,
    output logic        word_we,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_CNT,
        DATA,
`ifdef BOOT_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] shreg;
    logic [31:0] count;
    logic [31:0] word_cnt;
    logic [31:0] next_addr;
    logic [31:0] idle_cnt;
    logic        mid_frame;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic        accept;
    logic        last_byte;
    logic        timed_out;
    logic [31:0] word;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = accept && (idx == 2'd3);
    // Incoming byte enters at the top, so the first byte ends up in [7:0].
    assign word      = {byte_in, shreg[31:8]};
    assign timed_out = (TIMEOUT_CYCLES != 0) && mid_frame && !accept &&
                       (idle_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HDR_ADDR;
            idx        <= '0;
            shreg      <= '0;
            count      <= '0;
            word_cnt   <= '0;
            next_addr  <= '0;
            idle_cnt   <= '0;
            mid_frame  <= 1'b0;
            byte_ready <= 1'b1;
            cpu_rst    <= 1'b1;
            debug      <= 1'b0;
            word_we    <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            data_cpu   <= '0;
            waddr_cpu  <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            word_we <= 1'b0;
            if (accept) begin
                idx       <= idx + 2'd1;
                shreg     <= word;
                mid_frame <= 1'b1;
                idle_cnt  <= '0;
            end else if (mid_frame) begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            unique case (state)
                HDR_ADDR: if (last_byte) begin
                    next_addr <= word;
`ifdef BOOT_CHECKSUM_EN
                    csum      <= word;
`endif
                    state     <= HDR_CNT;
                end
                HDR_CNT: if (last_byte) begin
                    count <= word;
`ifdef BOOT_CHECKSUM_EN
                    csum  <= csum + word;
`endif
                    if (word > 32'(MAX_WORDS)) begin
                        state      <= ERR;
                        byte_ready <= 1'b0;
                        mid_frame  <= 1'b0;
                        load_err   <= 1'b1;
                    end else if (word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state      <= CSUM;
`else
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        mid_frame  <= 1'b0;
                        cpu_rst    <= 1'b0;
                        load_done  <= 1'b1;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (last_byte) begin
                    data_cpu  <= word;
                    waddr_cpu <= next_addr;
                    next_addr <= next_addr + ADDR_STRIDE;
                    word_we   <= 1'b1;
                    debug     <= 1'b1;
                    word_cnt  <= word_cnt + 32'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum      <= csum + word;
`endif
                    if (word_cnt == count - 32'd1) begin
`ifdef BOOT_CHECKSUM_EN
                        state      <= CSUM;
`else
                        // Last write still sees debug=1; DONE drops it next edge.
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        mid_frame  <= 1'b0;
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CSUM: if (last_byte) begin
                    byte_ready <= 1'b0;
                    mid_frame  <= 1'b0;
                    debug      <= 1'b0;
                    if (word == csum) begin
                        state     <= DONE;
                        cpu_rst   <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end
`endif
                DONE, ERR: if (start) begin
                    state      <= HDR_ADDR;
                    idx        <= '0;
                    shreg      <= '0;
                    count      <= '0;
                    word_cnt   <= '0;
                    idle_cnt   <= '0;
                    mid_frame  <= 1'b0;
                    byte_ready <= 1'b1;
                    cpu_rst    <= 1'b1;
                    debug      <= 1'b0;
                    load_done  <= 1'b0;
                    load_err   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                    csum       <= '0;
`endif
                end else if (state == DONE && !load_done) begin
                    debug     <= 1'b0;
                    cpu_rst   <= 1'b0;
                    load_done <= 1'b1;
                end
                default: ;
            endcase

            if (timed_out) begin
                state      <= ERR;
                byte_ready <= 1'b0;
                mid_frame  <= 1'b0;
                debug      <= 1'b0;
                load_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: randomized frames vs a frame-level model.
// Build with BOOT_CHECKSUM_EN to exercise the checksum trailer.
module tb_boot_loader;

    localparam int unsigned MAXW = 16384;
    localparam int unsigned TO   = 10;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        debug;
    logic [31:0] data_cpu;
    logic [31:0] waddr_cpu;
    logic        word_we;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        got_dbg[$];
    logic [31:0] frame_words[$];

    always #5 clk = ~clk;

    boot_loader #(
        .ADDR_STRIDE(4),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .debug(debug),
        .data_cpu(data_cpu),
        .waddr_cpu(waddr_cpu),
        .word_we(word_we),
        .cpu_rst(cpu_rst),
        .load_done(load_done),
        .load_err(load_err)
    );

    always @(negedge clk) begin
        if (word_we === 1'b1) begin
            got_addr.push_back(waddr_cpu);
            got_data.push_back(data_cpu);
            got_dbg.push_back(debug);
        end
    end

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
        got_dbg.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = b;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            idle(int'($urandom_range(gap, 0)));
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_end(output bit expired);
        expired = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            if (load_done || load_err) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({byte_ready, cpu_rst, load_done, load_err, debug} !== 5'b11000) begin
            failures++;
            $display("FAIL rearm got ready/rst/done/err/dbg=%b exp=11000",
                     {byte_ready, cpu_rst, load_done, load_err, debug});
        end
    endtask

    // Frame-level model: expected writes are base+4k with the k-th word.
    task automatic run_frame(input logic [31:0] base, input logic [31:0] n,
                             input int gap, input bit bad_csum);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] sum;
        bit          expired;
        bit          exp_done;
        clear_got();
        exp_done = (n <= MAXW) && !(CSUM_ON && bad_csum);
        sum = base + n;
        send_word(base, gap);
        send_word(n, gap);
        if (n <= MAXW) begin
            for (int k = 0; k < int'(n); k++) begin
                exp_addr.push_back(base + 32'(k) * 32'd4);
                exp_data.push_back(frame_words[k]);
                sum += frame_words[k];
                send_word(frame_words[k], gap);
            end
            if (CSUM_ON) send_word(bad_csum ? 32'h0 : sum, gap);
        end
        wait_end(expired);
        idle(1);
        checks++;
        if (expired) begin
            failures++;
            $display("FAIL end_wait got=no_end exp=done_or_err");
        end
        checks++;
        if (load_done !== exp_done || load_err !== !exp_done) begin
            failures++;
            $display("FAIL end_flags got done=%b err=%b exp done=%b",
                     load_done, load_err, exp_done);
        end
        checks++;
        if (cpu_rst !== !exp_done || debug !== 1'b0 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL end_ctrl got rst=%b dbg=%b rdy=%b exp rst=%b dbg=0 rdy=0",
                     cpu_rst, debug, byte_ready, !exp_done);
        end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d",
                     got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] ||
                got_dbg[i] !== 1'b1) begin
                failures++;
                $display("FAIL write%0d got=%h:%h dbg=%b exp=%h:%h dbg=1", i,
                         got_addr[i], got_data[i], got_dbg[i],
                         exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({byte_ready, cpu_rst, debug, word_we, load_done, load_err} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=110000",
                     {byte_ready, cpu_rst, debug, word_we, load_done, load_err});
        end
        checks++;
        if (data_cpu !== 32'h0 || waddr_cpu !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h:%h exp=0:0", waddr_cpu, data_cpu);
        end
    endtask

    task automatic test_spec_frame();
        frame_words = '{32'h0000_0013, 32'hDEAD_BEEF};
        run_frame(32'h0000_1000, 32'd2, 0, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        rearm();
        run_frame(32'h0000_1000, 32'd2, 0, 1'b1);
`endif
    endtask

    task automatic test_zero_count();
        rearm();
`ifdef BOOT_CHECKSUM_EN
        frame_words.delete();
        run_frame(32'h0000_0600, 32'd0, 1, 1'b0);
`else
        clear_got();
        send_word(32'h0000_0600, 0);
        send_word(32'h0, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        checks++;
        if (byte_ready !== 1'b0 || load_done !== 1'b1 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got rdy=%b done=%b rst=%b exp rdy=0 done=1 rst=0",
                     byte_ready, load_done, cpu_rst);
        end
        @(posedge clk);
        idle(3);
        checks++;
        if (got_addr.size() != 0 || load_done !== 1'b1 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_after got writes=%0d done=%b err=%b exp 0/1/0",
                     got_addr.size(), load_done, load_err);
        end
`endif
    endtask

    task automatic test_overflow();
        rearm();
        run_frame(32'h0000_1000, 32'h0000_4001, 0, 1'b0);
        rearm();
        run_frame($urandom, 32'h0000_4001 + $urandom_range(5000, 0), 1, 1'b0);
    endtask

    task automatic test_timeout();
        logic [31:0] sum;
        bit          expired;
        rearm();
        clear_got();
        send_word(32'h0000_2000, 0);
        send_word(32'd2, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(10);
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got err=%b exp=0", load_err);
        end
        @(negedge clk);
        checks++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0 ||
            got_addr.size() != 0) begin
            failures++;
            $display("FAIL timeout_err got err=%b rst=%b rdy=%b writes=%0d exp 1/1/0/0",
                     load_err, cpu_rst, byte_ready, got_addr.size());
        end
        rearm();
        clear_got();
        send_word(32'h0000_3000, 0);
        send_word(32'd2, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(9);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'hCAFE_F00D, 0);
        sum = 32'h0000_3000 + 32'd2 + 32'h4433_2211 + 32'hCAFE_F00D;
        if (CSUM_ON) send_word(sum, 0);
        wait_end(expired);
        idle(1);
        checks++;
        if (expired || load_done !== 1'b1 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL stall9_done got done=%b err=%b exp done=1 err=0",
                     load_done, load_err);
        end
        checks++;
        if (got_data.size() != 2 || got_data[0] !== 32'h4433_2211 ||
            got_addr[1] !== 32'h0000_3004) begin
            failures++;
            $display("FAIL stall9_writes got n=%0d exp n=2 d0=44332211 a1=00003004",
                     got_data.size());
        end
    endtask

    task automatic test_start_ignored();
        bit expired;
        rearm();
        clear_got();
        send_word(32'h0000_5000, 0);
        send_word(32'd1, 0);
        send_byte(8'h78);
        send_byte(8'h56);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h34);
        send_byte(8'h12);
        if (CSUM_ON) send_word(32'h0000_5001 + 32'h1234_5678, 0);
        wait_end(expired);
        idle(1);
        checks++;
        if (expired || load_done !== 1'b1 || got_data.size() != 1 ||
            got_data[0] !== 32'h1234_5678 || got_addr[0] !== 32'h0000_5000) begin
            failures++;
            $display("FAIL start_ignored got done=%b writes=%0d exp done=1 writes=1",
                     load_done, got_data.size());
        end
    endtask

    task automatic test_rst_mid();
        rearm();
        clear_got();
        send_word(32'h0000_4000, 0);
        send_word(32'd3, 0);
        send_word(32'h0102_0304, 0);
        send_word(32'h0506_0708, 0);
        idle(2);
        checks++;
        if (got_addr.size() != 2 || debug !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got writes=%0d dbg=%b exp 2/1",
                     got_addr.size(), debug);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, cpu_rst, debug, word_we, load_done, load_err} !== 6'b110000 ||
            data_cpu !== 32'h0 || waddr_cpu !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got flags=%b bus=%h:%h exp 110000 0:0",
                     {byte_ready, cpu_rst, debug, word_we, load_done, load_err},
                     waddr_cpu, data_cpu);
        end
        @(negedge clk);
        rst = 1'b0;
        frame_words = '{$urandom, $urandom, $urandom};
        run_frame($urandom, 32'd3, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] base;
        int          n;
        for (int f = 0; f < 8; f++) begin
            rearm();
            n = int'($urandom_range(6, 1));
            base = (f == 2) ? 32'hFFFF_FFF8 : $urandom;
            frame_words.delete();
            for (int k = 0; k < n; k++) frame_words.push_back($urandom);
            run_frame(base, 32'(n), 2, f == 5);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h0;
        test_reset();
        test_spec_frame();
        test_zero_count();
        test_overflow();
        test_timeout();
        test_start_ignored();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
